// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: loader states, image framing constants.
// ST_CSUM exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    ST_CSUM   = 3'd3,
`endif
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream, instruction-memory and status signals between a host and the program loader.
interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  // A byte moves on a rising clk edge only when rx_valid and rx_ready are both high.
  // rx_valid may drop at any time; rx_ready never depends on rx_valid.
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_clr;
  logic              done;
  logic              err;

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_clr, done, err
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata, cpu_clr, done, err
  );
endinterface

// File: rtl/byte_to_word.sv
// Shifts accepted payload bytes MSB-first into a 32-bit assembly register and counts
// bytes within the current word; o_word_last flags the byte that completes a word.
module byte_to_word
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_asm,
  output logic        o_word_last
);

  logic [31:0]      r_asm;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_asm <= '0;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_asm <= {r_asm[23:0], i_byte};
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_asm       = r_asm;
  assign o_word_last = i_shift && (r_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a length-prefixed big-endian byte image into
// instruction memory and holds the CPU in clear until done. LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module prog_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         clr_n,
  prog_loader_if.slave bus,
  output state_t       o_dbg_state
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t ST_TAIL = ST_CSUM;
`else
  localparam state_t ST_TAIL = ST_DONE;
`endif

  state_t            r_state, w_next;
  logic [7:0]        r_hdr_hi;
  logic [15:0]       r_n;
  logic [15:0]       r_widx;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;

  logic              w_rx_ready;
  logic              w_accept;
  logic              w_shift;
  logic              w_clr;
  logic              w_word_last;
  logic              w_last_word;
  logic [15:0]       w_hdr_n;
  logic [31:0]       w_asm;

  assign w_rx_ready  = (r_state != ST_DONE) && (r_state != ST_ERR);
  assign w_accept    = bus.rx_valid && w_rx_ready;
  assign w_shift     = w_accept && (r_state == ST_DATA);
  assign w_clr       = bus.start && !w_rx_ready;
  assign w_hdr_n     = {r_hdr_hi, bus.rx_data};
  assign w_last_word = (r_widx + 16'd1) == r_n;

  byte_to_word u_b2w (
    .clk         (clk),
    .rst_n       (clr_n),
    .i_clr       (w_clr),
    .i_shift     (w_shift),
    .i_byte      (bus.rx_data),
    .o_asm       (w_asm),
    .o_word_last (w_word_last)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_xor;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_xor <= '0;
    end else if (w_clr) begin
      r_xor <= '0;
    end else if (w_accept && (r_state != ST_CSUM)) begin
      r_xor <= r_xor ^ bus.rx_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= ST_HDR_HI;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_HDR_HI: if (w_accept) w_next = ST_HDR_LO;
      ST_HDR_LO: begin
        if (w_accept) begin
          if ({1'b0, w_hdr_n} > DEPTH_L) w_next = ST_ERR;
          else if (w_hdr_n == 16'd0)     w_next = ST_TAIL;
          else                           w_next = ST_DATA;
        end
      end
      ST_DATA:   if (w_word_last && w_last_word) w_next = ST_TAIL;
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (w_accept) w_next = (bus.rx_data == r_xor) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE:   if (bus.start) w_next = ST_HDR_HI;
      ST_ERR:    if (bus.start) w_next = ST_HDR_HI;
      default:   w_next = ST_HDR_HI;
    endcase
  end

  // The write pulse trails the completing byte by one cycle, so the assembly
  // register already holds the full word while imem_we is high.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_hdr_hi <= '0;
      r_n      <= '0;
      r_widx   <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_clr) begin
        r_widx <= '0;
      end else if (w_word_last) begin
        r_we   <= 1'b1;
        r_addr <= r_widx[ADDR_W-1:0];
        r_widx <= r_widx + 16'd1;
      end
      if (w_accept && (r_state == ST_HDR_HI)) r_hdr_hi <= bus.rx_data;
      if (w_accept && (r_state == ST_HDR_LO)) r_n      <= w_hdr_n;
    end
  end

  assign bus.rx_ready   = w_rx_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = w_asm;
  assign bus.done       = (r_state == ST_DONE);
  assign bus.err        = (r_state == ST_ERR);
  assign bus.cpu_clr    = (r_state != ST_DONE);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: random images built from the image format
// rules, a write scoreboard fed by a negedge monitor, and directed boundary scenarios.
module tb_prog_loader;
  import loader_pkg::*;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic   clk   = 1'b0;
  logic   clr_n = 1'b0;
  state_t dbg_state;
  int     total = 0;
  int     bad   = 0;

  logic [7:0]        tx_q[$];
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] got_q[$];
  logic              exp_done, exp_err;
  logic [31:0]       ex_words [2] = '{32'h200100C8, 32'h28020001};
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_flip = 8'h00;
`endif

  int                mon_double   = 0;
  int                mon_addr_err = 0;
  logic              mon_prev_we  = 1'b0;
  logic [ADDR_W-1:0] mon_last_addr = '0;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  // monitor: capture write pulses, check pulse width and address hold
  always @(negedge clk) begin
    if (clr_n) begin
      if (bus.imem_we) got_q.push_back({bus.imem_addr, bus.imem_wdata});
      if (bus.imem_we && mon_prev_we) mon_double++;
      if (!bus.imem_we && (bus.imem_addr !== mon_last_addr)) mon_addr_err++;
      mon_prev_we   = bus.imem_we;
      mon_last_addr = bus.imem_addr;
    end else begin
      mon_prev_we   = 1'b0;
      mon_last_addr = '0;
    end
  end

  // reference model: the byte image and the writes it must produce
  task automatic build_image(input int n, input int fixed);
    logic [31:0] w;
    tx_q.delete(); exp_q.delete(); got_q.delete();
    tx_q.push_back(8'(n >> 8));
    tx_q.push_back(8'(n));
    exp_err  = (n > DEPTH);
    exp_done = !exp_err;
    if (!exp_err) begin
      for (int k = 0; k < n; k++) begin
        w = (fixed != 0) ? ex_words[k] : $urandom;
        for (int b = 3; b >= 0; b--) tx_q.push_back(w[8*b +: 8]);
        exp_q.push_back({ADDR_W'(k), w});
      end
`ifdef LOADER_CHECKSUM_EN
      begin
        logic [7:0] x;
        x = 8'h00;
        foreach (tx_q[i]) x ^= tx_q[i];
        tx_q.push_back(x ^ csum_flip);
        if (csum_flip != 8'h00) begin exp_err = 1'b1; exp_done = 1'b0; end
      end
`endif
    end
  endtask

  // driver: offers tx_q bytes; gaps!=0 adds random idle cycles and stray start pulses
  task automatic drive(input int gaps);
    int i = 0;
    int guard = 0;
    while (i < tx_q.size() && guard < 20000) begin
      bus.start = (gaps != 0) && ($urandom_range(0, 7) == 0);
      if ((gaps != 0) && ($urandom_range(0, 2) == 0)) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
      end else begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = tx_q[i];
      end
      @(negedge clk);
      if (bus.rx_valid && bus.rx_ready) i++;
      @(posedge clk); #1;
      guard++;
    end
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    total++;
    if (i != tx_q.size()) begin
      bad++;
      $display("FAIL drive_timeout accepted=%0d want=%0d", i, tx_q.size());
    end
  endtask

  task automatic rearm();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    #1;
    total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready got=%b want=1", bus.rx_ready); end
    total++; if (bus.imem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", bus.imem_we); end
    total++; if (bus.imem_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", bus.imem_addr); end
    total++; if (bus.imem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", bus.imem_wdata); end
    total++; if (bus.cpu_clr !== 1'b1) begin bad++; $display("FAIL reset_cpu_clr got=%b want=1", bus.cpu_clr); end
    total++; if ({bus.done, bus.err} !== 2'b00) begin bad++; $display("FAIL reset_status got=%b want=00", {bus.done, bus.err}); end
    total++; if (dbg_state !== ST_HDR_HI) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_HDR_HI); end
    @(posedge clk); #1;
    clr_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_example();
    rearm();
    build_image(2, 1);
    drive(0);
`ifndef LOADER_CHECKSUM_EN
    total++; if ({bus.imem_we, bus.imem_addr} !== {1'b1, ADDR_W'(1)}) begin bad++; $display("FAIL ex_last_pulse got=%b/%0d want=1/1", bus.imem_we, bus.imem_addr); end
    total++; if ({bus.done, bus.cpu_clr} !== 2'b10) begin bad++; $display("FAIL ex_release got=%b want=10", {bus.done, bus.cpu_clr}); end
    @(posedge clk); #1;
    total++; if (bus.imem_we !== 1'b0) begin bad++; $display("FAIL ex_pulse_width got=%b want=0", bus.imem_we); end
`endif
    settle();
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL ex_count got=%0d want=2", got_q.size()); end
    else begin
      total++; if (got_q[0] !== {ADDR_W'(0), 32'h200100C8}) begin bad++; $display("FAIL ex_word0 got=%h want=%h", got_q[0], {ADDR_W'(0), 32'h200100C8}); end
      total++; if (got_q[1] !== {ADDR_W'(1), 32'h28020001}) begin bad++; $display("FAIL ex_word1 got=%h want=%h", got_q[1], {ADDR_W'(1), 32'h28020001}); end
    end
    total++; if ({bus.done, bus.err, bus.cpu_clr} !== 3'b100) begin bad++; $display("FAIL ex_status got=%b want=100", {bus.done, bus.err, bus.cpu_clr}); end
  endtask

  task automatic test_empty();
    rearm();
    build_image(0, 0);
    drive(0);
    settle();
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL empty_writes got=%0d want=0", got_q.size()); end
    total++; if ({bus.done, bus.err, bus.cpu_clr} !== 3'b100) begin bad++; $display("FAIL empty_status got=%b want=100", {bus.done, bus.err, bus.cpu_clr}); end
  endtask

  task automatic test_oversize();
    rearm();
    build_image(DEPTH + 1, 0);
    drive(0);
    settle();
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL big_writes got=%0d want=0", got_q.size()); end
    total++; if ({bus.done, bus.err, bus.cpu_clr, bus.rx_ready} !== 4'b0110) begin bad++; $display("FAIL big_status got=%b want=0110", {bus.done, bus.err, bus.cpu_clr, bus.rx_ready}); end
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL big_stuck got=%b want=1", bus.err); end
    rearm();
    total++; if ({bus.rx_ready, bus.err, bus.cpu_clr} !== 3'b101) begin bad++; $display("FAIL big_rearm got=%b want=101", {bus.rx_ready, bus.err, bus.cpu_clr}); end
    total++; if (dbg_state !== ST_HDR_HI) begin bad++; $display("FAIL big_rearm_state got=%0d want=%0d", dbg_state, ST_HDR_HI); end
  endtask

  task automatic test_gaps();
    rearm();
    build_image(2, 1);
    drive(1);
    settle();
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL gaps_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[k]) begin
      total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL gaps_word%0d got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
    total++; if ({bus.done, bus.err} !== {exp_done, exp_err}) begin bad++; $display("FAIL gaps_status got=%b want=%b", {bus.done, bus.err}, {exp_done, exp_err}); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      rearm();
      build_image($urandom_range(1, 9), 0);
      drive(t % 2);
      settle();
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", t, got_q.size(), exp_q.size()); end
      else foreach (exp_q[k]) begin
        total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL rand%0d_word%0d got=%h want=%h", t, k, got_q[k], exp_q[k]); end
      end
      total++; if ({bus.done, bus.err, bus.cpu_clr} !== {exp_done, exp_err, !exp_done}) begin bad++; $display("FAIL rand%0d_status got=%b want=%b", t, {bus.done, bus.err, bus.cpu_clr}, {exp_done, exp_err, !exp_done}); end
    end
  endtask

  task automatic test_full_depth();
    int nerr = 0;
    rearm();
    build_image(DEPTH, 0);
    drive(0);
    settle();
    total++; if (got_q.size() != DEPTH) begin bad++; $display("FAIL full_count got=%0d want=%0d", got_q.size(), DEPTH); end
    else begin
      foreach (exp_q[k]) if (got_q[k] !== exp_q[k]) nerr++;
      total++; if (nerr != 0) begin bad++; $display("FAIL full_words got=%0d_wrong want=0_wrong", nerr); end
      total++; if (got_q[DEPTH-1][ADDR_W+31:32] !== ADDR_W'(DEPTH - 1)) begin bad++; $display("FAIL full_last_addr got=%0d want=%0d", got_q[DEPTH-1][ADDR_W+31:32], DEPTH - 1); end
    end
    total++; if (bus.done !== exp_done) begin bad++; $display("FAIL full_done got=%b want=%b", bus.done, exp_done); end
  endtask

  task automatic test_reset_mid();
    rearm();
    build_image(2, 0);
    while (tx_q.size() > 6) void'(tx_q.pop_back());
    drive(0);
    clr_n = 1'b0;
    #1;
    total++; if ({bus.rx_ready, bus.imem_we, bus.cpu_clr, bus.done, bus.err} !== 5'b10100) begin bad++; $display("FAIL mid_reset_ctl got=%b want=10100", {bus.rx_ready, bus.imem_we, bus.cpu_clr, bus.done, bus.err}); end
    total++; if ({bus.imem_addr, bus.imem_wdata} !== '0) begin bad++; $display("FAIL mid_reset_bus got=%h want=0", {bus.imem_addr, bus.imem_wdata}); end
    @(posedge clk); #1;
    clr_n = 1'b1;
    @(posedge clk); #1;
    build_image(2, 0);
    drive(0);
    settle();
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[k]) begin
      total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL mid_word%0d got=%h want=%h", k, got_q[k], exp_q[k]); end
    end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL mid_done got=%b want=1", bus.done); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_csum();
    rearm();
    csum_flip = 8'h01;
    build_image(2, 1);
    csum_flip = 8'h00;
    drive(0);
    settle();
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL csum_writes got=%0d want=2", got_q.size()); end
    total++; if ({bus.done, bus.err, bus.cpu_clr} !== 3'b011) begin bad++; $display("FAIL csum_bad_status got=%b want=011", {bus.done, bus.err, bus.cpu_clr}); end
    rearm();
    csum_flip = 8'h01;
    build_image(0, 0);
    csum_flip = 8'h00;
    drive(0);
    settle();
    total++; if ({bus.done, bus.err} !== 2'b01) begin bad++; $display("FAIL csum_empty_bad got=%b want=01", {bus.done, bus.err}); end
  endtask
`endif

  task automatic test_monitor();
    total++; if (mon_double != 0) begin bad++; $display("FAIL we_width got=%0d_long want=0_long", mon_double); end
    total++; if (mon_addr_err != 0) begin bad++; $display("FAIL addr_hold got=%0d_changes want=0_changes", mon_addr_err); end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_example();
    test_empty();
    test_oversize();
    test_gaps();
    test_random();
    test_full_depth();
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_bad_csum();
`endif
    test_monitor();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
